// File: rtl/result_capture_unit_pkg.sv
// Shared encodings for the result capture path: the controller's result
// bus commands and the capture unit's own state.
package resultGroup;

  typedef enum logic [2:0] {
    NO_OP           = 3'd0,
    LOAD_ALU        = 3'd1,
    LOAD_DIVIDER    = 3'd2,
    LOAD_MULTIPLIER = 3'd3,
    LOAD_SHIFTER    = 3'd4
  } controlBus;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MUL = 2'd1,
    WAIT_DIV = 2'd2
  } captureState;

endpackage

// File: rtl/result_capture_unit_timeout_counter.sv
// Wait-cycle counter for multi-cycle units; flags the last permitted
// wait cycle so the capture FSM can abandon an unresponsive unit.
module result_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] waitCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCount <= '0;
    end else if (clear) begin
      waitCount <= '0;
    end else if (count) begin
      waitCount <= waitCount + 1'b1;
    end
  end

  assign expired = (waitCount == LAST);

endmodule

// File: rtl/result_capture_unit.sv
// Result bus consumer: captures ALU/shifter results in one cycle and waits
// on the multiplier/divider done handshake, stalling the controller meanwhile.
import resultGroup::*;

module result_capture_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  controlBus             resultControl,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic [DATA_WIDTH-1:0] shifterResult,
  input  logic [DATA_WIDTH-1:0] multiplierLow,
  input  logic [DATA_WIDTH-1:0] multiplierHigh,
  input  logic                  multiplierDone,
  input  logic [DATA_WIDTH-1:0] dividerQuotient,
  input  logic [DATA_WIDTH-1:0] dividerRemainder,
  input  logic                  dividerDone,
  input  logic                  dividerDivZero,
  output logic [DATA_WIDTH-1:0] resultLow,
  output logic [DATA_WIDTH-1:0] resultHigh,
  output logic                  resultValid,
  output logic                  busy,
  output logic                  divideError,
  output logic                  unitTimeout
);

  captureState state;

  logic                  waitMul, waitDiv;
  logic                  unitDone, divZeroEvent, timeoutEvent;
  logic                  counterClear, counterCount, expired;
  logic                  captureEn;
  logic [DATA_WIDTH-1:0] captureLow, captureHigh;

  always_comb begin
    waitMul      = (state == WAIT_MUL);
    waitDiv      = (state == WAIT_DIV);
    unitDone     = (waitMul && multiplierDone) || (waitDiv && dividerDone);
    divZeroEvent = waitDiv && dividerDone && dividerDivZero;
    // A done in the final wait cycle takes priority over the timeout.
    timeoutEvent = (waitMul || waitDiv) && !unitDone && expired;
    counterClear = (state == IDLE);
    counterCount = !counterClear && !unitDone && !expired;

    captureEn   = 1'b0;
    captureLow  = '0;
    captureHigh = '0;
    if (state == IDLE) begin
      if (enable) begin
        case (resultControl)
          LOAD_ALU: begin
            captureEn  = 1'b1;
            captureLow = aluResult;
          end
          LOAD_SHIFTER: begin
            captureEn  = 1'b1;
            captureLow = shifterResult;
          end
          default: ;
        endcase
      end
    end else if (waitMul && multiplierDone) begin
      captureEn   = 1'b1;
      captureLow  = multiplierLow;
      captureHigh = multiplierHigh;
    end else if (waitDiv && dividerDone && !dividerDivZero) begin
      captureEn   = 1'b1;
      captureLow  = dividerQuotient;
      captureHigh = dividerRemainder;
    end
  end

  result_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (counterClear),
    .count  (counterCount),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      resultLow   <= '0;
      resultHigh  <= '0;
      resultValid <= 1'b0;
      divideError <= 1'b0;
      unitTimeout <= 1'b0;
    end else begin
      divideError <= divZeroEvent;
      unitTimeout <= timeoutEvent;

      // Valid holds through stalls and clears on the first advancing cycle.
      if (captureEn) begin
        resultLow   <= captureLow;
        resultHigh  <= captureHigh;
        resultValid <= 1'b1;
      end else if (enable) begin
        resultValid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable && resultControl == LOAD_MULTIPLIER) begin
            state <= WAIT_MUL;
          end else if (enable && resultControl == LOAD_DIVIDER) begin
            state <= WAIT_DIV;
          end
        end
        WAIT_MUL, WAIT_DIV: begin
          if (unitDone || timeoutEvent) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_result_capture_unit.sv
// Bench for result_capture_unit: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_result_capture_unit;
  import resultGroup::*;

  localparam int DW  = 32;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  controlBus     ctl = NO_OP;
  logic [DW-1:0] alu = '0, shf = '0, ml = '0, mh = '0, q = '0, r = '0;
  logic          md = 1'b0, dd = 1'b0, dz = 1'b0;
  logic [DW-1:0] rl, rh;
  logic          rv, busy, derr, tmo;

  result_capture_unit #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .resultControl(ctl),
    .aluResult(alu), .shifterResult(shf),
    .multiplierLow(ml), .multiplierHigh(mh), .multiplierDone(md),
    .dividerQuotient(q), .dividerRemainder(r), .dividerDone(dd),
    .dividerDivZero(dz),
    .resultLow(rl), .resultHigh(rh), .resultValid(rv), .busy(busy),
    .divideError(derr), .unitTimeout(tmo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 = ready, 1 = awaiting product, 2 = awaiting quotient.
  int            m_mode = 0;
  int            m_waited = 0;
  logic [DW-1:0] e_low = '0, e_high = '0;
  logic          e_valid = 1'b0, e_derr = 1'b0, e_tmo = 1'b0;

  task automatic model_zero();
    m_mode = 0; m_waited = 0;
    e_low = '0; e_high = '0; e_valid = 1'b0; e_derr = 1'b0; e_tmo = 1'b0;
  endtask

  task automatic model_edge();
    bit            cap = 0;
    bit            de = 0;
    bit            to = 0;
    logic [DW-1:0] nl = '0, nh = '0;
    if (m_mode == 0) begin
      if (enable) begin
        if (ctl == LOAD_ALU) begin cap = 1; nl = alu; end
        else if (ctl == LOAD_SHIFTER) begin cap = 1; nl = shf; end
        else if (ctl == LOAD_MULTIPLIER) begin m_mode = 1; m_waited = 0; end
        else if (ctl == LOAD_DIVIDER) begin m_mode = 2; m_waited = 0; end
      end
    end else begin
      if ((m_mode == 1) ? md : dd) begin
        if (m_mode == 1) begin cap = 1; nl = ml; nh = mh; end
        else if (dz) de = 1;
        else begin cap = 1; nl = q; nh = r; end
        m_mode = 0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin to = 1; m_mode = 0; end
      end
    end
    if (cap) begin e_low = nl; e_high = nh; e_valid = 1'b1; end
    else if (enable) e_valid = 1'b0;
    e_derr = de;
    e_tmo  = to;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_zero();
    else model_edge();
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("resultLow", rl, e_low);
    chk("resultHigh", rh, e_high);
    chk("resultValid", rv, e_valid);
    chk("busy", busy, m_mode != 0);
    chk("divideError", derr, e_derr);
    chk("unitTimeout", tmo, e_tmo);
  end

  initial begin
    bit quiet;
    repeat (2) cyc();
    at_neg();
    chk("rst_low", rl, 0);
    chk("rst_valid", rv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", tmo, 0);
    reset = 1'b0;
    enable = 1'b1;

    // ALU capture
    ctl = LOAD_ALU; alu = 32'hDEADBEEF; cyc(); ctl = NO_OP;
    at_neg();
    chk("t1_low", rl, 32'hDEADBEEF);
    chk("t1_high", rh, 0);
    chk("t1_valid", rv, 1);
    chk("t1_busy", busy, 0);

    // Multiplier: done on the accept cycle is ignored; controller commands ignored while busy
    ctl = LOAD_MULTIPLIER; md = 1'b1; mh = 32'h1; ml = 32'h1234; cyc();
    ctl = NO_OP; md = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg(); chk("t2_busy", busy, 1); ctl = LOAD_ALU; alu = 32'h5555AAAA; cyc();
    end
    at_neg(); chk("t2_busy", busy, 1);
    md = 1'b1; mh = 32'h0000_0001; ml = 32'h8000_0000; cyc(); md = 1'b0; ctl = NO_OP;
    at_neg();
    chk("t2_high", rh, 32'h1);
    chk("t2_low", rl, 32'h8000_0000);
    chk("t2_valid", rv, 1);
    chk("t2_busy", busy, 0);

    // Divide by zero
    ctl = LOAD_DIVIDER; cyc(); ctl = NO_OP;
    cyc(); cyc();
    dd = 1'b1; dz = 1'b1; q = 32'h0BAD0BAD; r = 32'h0F0F0F0F; cyc(); dd = 1'b0; dz = 1'b0;
    at_neg();
    chk("t3_derr", derr, 1);
    chk("t3_valid", rv, 0);
    chk("t3_low", rl, 32'h8000_0000);
    chk("t3_high", rh, 32'h1);
    chk("t3_busy", busy, 0);
    cyc(); at_neg(); chk("t3_pulse", derr, 0);

    // Timeout
    ctl = LOAD_DIVIDER; cyc(); ctl = NO_OP;
    for (int n = 1; n <= TMO; n++) begin
      cyc(); at_neg();
      chk("t4_timeout", tmo, n == TMO);
      chk("t4_busy", busy, n != TMO);
    end
    cyc(); at_neg(); chk("t4_pulse", tmo, 0);

    // Done in the final wait cycle beats the timeout
    ctl = LOAD_DIVIDER; cyc(); ctl = NO_OP;
    for (int n = 1; n < TMO; n++) cyc();
    dd = 1'b1; q = 32'hCAFEF00D; r = 32'h7; cyc(); dd = 1'b0;
    at_neg();
    chk("t4b_low", rl, 32'hCAFEF00D);
    chk("t4b_high", rh, 32'h7);
    chk("t4b_valid", rv, 1);
    chk("t4b_tmo", tmo, 0);
    chk("t4b_busy", busy, 0);

    // Stall hold
    ctl = LOAD_SHIFTER; shf = 32'h0000_00F0; cyc(); ctl = NO_OP; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); at_neg();
      chk("t5_hold", rv, 1);
      chk("t5_low", rl, 32'hF0);
    end
    enable = 1'b1; cyc(); at_neg(); chk("t5_clear", rv, 0);
    ctl = LOAD_ALU; alu = 32'h11111111; cyc();
    alu = 32'h22222222; cyc(); ctl = NO_OP;
    at_neg();
    chk("t5_recap_valid", rv, 1);
    chk("t5_recap_low", rl, 32'h22222222);

    // Reset during a multiplier wait
    ctl = LOAD_MULTIPLIER; cyc(); ctl = NO_OP;
    cyc(); cyc();
    #2 reset = 1'b1; model_zero();
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_low", rl, 0);
    chk("t6_valid", rv, 0);
    cyc(); reset = 1'b0;
    md = 1'b1; ml = 32'h12345678; mh = 32'h9ABCDEF0; cyc(); md = 1'b0;
    at_neg();
    chk("t6_late_low", rl, 0);
    chk("t6_late_valid", rv, 0);
    chk("t6_late_busy", busy, 0);

    // Random traffic, with quiet stretches long enough to force timeouts
    for (int i = 0; i < 3000; i++) begin
      quiet  = ((i / 150) % 4) == 3;
      enable = $urandom_range(0, 3) != 0;
      ctl    = controlBus'(3'($urandom_range(0, 4)));
      alu = $urandom; shf = $urandom; ml = $urandom; mh = $urandom;
      q   = $urandom; r   = $urandom;
      md  = !quiet && ($urandom_range(0, 5) == 0);
      dd  = !quiet && ($urandom_range(0, 5) == 0);
      dz  = $urandom_range(0, 2) == 0;
      cyc();
    end
    md = 1'b0; dd = 1'b0; ctl = NO_OP;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
